ahb_ram_ctrl: RTL and testbench
===============================

AHB_RAM_CTRL -- requirements
Module: ahb_ram_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, RAM word-address width (RAM depth = 2^ADDR_W words of 32 bits).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; all state on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- hsel  in  1  slave select
- htrans  in  2  AHB transfer type; htrans[1]=1 means NONSEQ/SEQ
- hwrite  in  1  1=write
- hsize  in  3  000 byte, 001 half, 010 word
- haddr  in  32  byte address
- hwdata  in  32  write data, valid in data phase
- hrdata  out  32  read data
- hready  out  1  transfer done / slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- ram_addr  out  ADDR_W  word address, haddr[ADDR_W+1:2]
- ram_ren  out  1  RAM read strobe; data on ram_rdata next cycle
- ram_wen  out  1  RAM write strobe, full 32-bit word
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word

Function
REQ-003 SHALL accept an address phase when hsel & htrans[1] & hready, latching haddr, hsize and hwrite.
REQ-004 SHALL complete htrans[1]=0 or hsel=0 cycles with OKAY and zero wait states, with no RAM access.
REQ-005 SHALL implement states IDLE, READ, RMW, ERR1, ERR2.
REQ-006 Read: IDLE->READ. Data-phase cycle 1 drives ram_ren=1 and hready=0. Cycle 2 drives hrdata=ram_rdata (full word) and hready=1. Latency is 1 wait state.
REQ-007 Word write: stays in IDLE. The data-phase cycle drives ram_wen=1 and ram_wdata=hwdata with hready=1. Zero wait states.
REQ-008 Byte/half write: IDLE->RMW. Cycle 1: ram_ren=1, hwdata captured, hready=0. Cycle 2: ram_wen=1, hready=1, ram_wdata = ram_rdata with the addressed lanes replaced.
REQ-009 Lane rule for byte writes: haddr[1:0]=n replaces bits [8n+7:8n] with hwdata[8n+7:8n].
REQ-010 Lane rule for half writes: haddr[1]=h replaces bits [16h+15:16h] with hwdata[16h+15:16h].
REQ-011 SHALL accept a new address phase in any cycle where hready=1 (pipelined). The next state is chosen from the new transfer.
REQ-012 A read that immediately follows a write to the same word SHALL return the written data. The RAM write occurs before the read strobe, so no forwarding is required.
REQ-013 ram_ren and ram_wen SHALL never be asserted in the same cycle.
REQ-014 hrdata SHALL hold its last value outside read completion cycles.
REQ-015 hready and hresp SHALL be registered outputs of the FSM; the RAM strobes may be combinational from state.

Reset
REQ-016 Assertion of n_rst SHALL immediately force state=IDLE, hready=1, hresp=0, hrdata=0, ram_ren=0, ram_wen=0, ram_wdata=0 and ram_addr=0, including mid-READ or mid-RMW.
REQ-017 A transfer aborted by reset SHALL NOT produce a RAM write after reset is released.

Configuration
REQ-018 Macro AHB_RAM_CTRL_ERR_EN, when defined, SHALL enable error checking. Illegal transfers are hsize>010, a half access with haddr[0]=1, or a word access with haddr[1:0]!=0.
REQ-019 With AHB_RAM_CTRL_ERR_EN defined, an illegal transfer SHALL go IDLE->ERR1->ERR2->IDLE:
- ERR1: hresp=1, hready=0
- ERR2: hresp=1, hready=1
- no RAM strobe is asserted
REQ-020 Without AHB_RAM_CTRL_ERR_EN, an illegal transfer SHALL have its address aligned down, with hsize>010 treated as a word access. hresp is tied 0 and ERR1/ERR2 are not built.

Verification
REQ-021 Word write 0xDEADBEEF to 0x10, then word read of 0x10 -> write: ram_wen=1 with ram_addr=4 and 0 waits; read: 1 wait, then hrdata=0xDEADBEEF.
REQ-022 Word at 0x20 = 0x11223344; byte write hwdata=0x0000AA00 at 0x21 -> ram_ren then ram_wen; RAM word becomes 0x1122AA44; 1 wait state.
REQ-023 Word at 0x20 = 0x11223344; half write hwdata=0xBEEF0000 at 0x22 -> RAM word becomes 0xBEEF3344.
REQ-024 Back-to-back pipelined transfers: word write 0x5 to 0x30, then read 0x30, then byte write 0x77 to 0x30 -> read returns 0x00000005; final RAM word 0x00000077; ram_ren and ram_wen never high together.
REQ-025 With AHB_RAM_CTRL_ERR_EN: word read at 0x31 -> hresp=1,hready=0 then hresp=1,hready=1, no ram_ren. Without the macro: same transfer reads word 0x30 with OKAY.
REQ-026 n_rst pulsed low during RMW cycle 1 of a byte write -> outputs take reset values immediately; no ram_wen after release; target RAM word unchanged.

Source files
------------

// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave in front of a synchronous 32-bit single-port RAM; sub-word writes use read-modify-write.
// Optional macro AHB_RAM_CTRL_ERR_EN builds ERROR responses for illegal size/alignment.
module ahb_ram_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       haddr,
    input  logic [31:0]       hwdata,
    output logic [31:0]       hrdata,
    output logic              hready,
    output logic              hresp,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
`ifdef AHB_RAM_CTRL_ERR_EN
        ERR1,
        ERR2,
`endif
        RMW
    } state_e;

    state_e              state_q, state_d;
    logic                ph_q, ph_d;       // 0: first data-phase cycle of READ/RMW, 1: completion cycle
    logic                ww_q, ww_d;       // word-write data phase in progress
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [31:0]         hrdata_q, hrdata_d;
    logic                hready_q, hready_d;
    logic                accept;
    logic                is_word;
    logic [3:0]          lane_mask;
    logic [31:0]         merged;

    logic unused_ok;
    assign unused_ok = ^{htrans[0], haddr[31:ADDR_W+2]};

    assign accept  = hsel & htrans[1] & hready_q;
    assign is_word = hsize[2] | hsize[1];

`ifdef AHB_RAM_CTRL_ERR_EN
    logic hresp_q, hresp_d;
    logic illegal;
    assign illegal = (hsize > 3'b010)
                   | ((hsize == 3'b001) & haddr[0])
                   | ((hsize == 3'b010) & (haddr[1:0] != 2'b00));
    assign hresp = hresp_q;
`else
    assign hresp = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ph_d     = 1'b0;
        ww_d     = 1'b0;
        addr_d   = addr_q;
        size_d   = size_q;
        off_d    = off_q;
        wdat_d   = wdat_q;
        hrdata_d = hrdata_q;
        case (state_q)
            READ: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                    hrdata_d = ram_rdata;
                end
            end
            RMW: begin
                if (!ph_q) begin
                    ph_d   = 1'b1;
                    wdat_d = hwdata;
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef AHB_RAM_CTRL_ERR_EN
            ERR1:    state_d = ERR2;
            ERR2:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // A new address phase overrides the default transition of the completing transfer.
        if (accept) begin
            addr_d = haddr[ADDR_W+1:2];
            size_d = hsize;
            off_d  = haddr[1:0];
            ph_d   = 1'b0;
`ifdef AHB_RAM_CTRL_ERR_EN
            if (illegal)
                state_d = ERR1;
            else
`endif
            if (!hwrite)
                state_d = READ;
            else if (is_word) begin
                state_d = IDLE;
                ww_d    = 1'b1;
            end else
                state_d = RMW;
        end

        hready_d = 1'b1;
        if ((state_d == READ || state_d == RMW) && !ph_d)
            hready_d = 1'b0;
`ifdef AHB_RAM_CTRL_ERR_EN
        if (state_d == ERR1)
            hready_d = 1'b0;
        hresp_d = (state_d == ERR1) || (state_d == ERR2);
`endif
    end

    always_comb begin
        if (size_q == 3'b001)
            lane_mask = off_q[1] ? 4'b1100 : 4'b0011;
        else
            lane_mask = 4'b0001 << off_q;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = lane_mask[i] ? wdat_q[8*i +: 8] : ram_rdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            ph_q     <= 1'b0;
            ww_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            off_q    <= '0;
            wdat_q   <= '0;
            hrdata_q <= '0;
            hready_q <= 1'b1;
`ifdef AHB_RAM_CTRL_ERR_EN
            hresp_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            ww_q     <= ww_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            off_q    <= off_d;
            wdat_q   <= wdat_d;
            hrdata_q <= hrdata_d;
            hready_q <= hready_d;
`ifdef AHB_RAM_CTRL_ERR_EN
            hresp_q  <= hresp_d;
`endif
        end
    end

    assign hready    = hready_q;
    assign ram_addr  = addr_q;
    assign ram_ren   = (state_q == READ || state_q == RMW) && !ph_q;
    assign ram_wen   = ww_q || (state_q == RMW && ph_q);
    assign ram_wdata = ww_q ? hwdata : ((state_q == RMW && ph_q) ? merged : 32'h0);
    assign hrdata    = (state_q == READ && ph_q) ? ram_rdata : hrdata_q;

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// Bench for ahb_ram_ctrl: pipelined AHB master, synchronous RAM model and a transaction-level reference memory.
module tb_ahb_ram_ctrl;
    localparam int ADDR_W = 10;
    localparam int MAXT   = 64;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              hsel;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       haddr;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hready;
    logic              hresp;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ren;
    logic              ram_wen;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    ahb_ram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model and strobe monitor
    logic [31:0]       mem [2**ADDR_W];
    int                wen_cnt;
    int                ren_cnt;
    bit                both_hi;
    logic [ADDR_W-1:0] last_wen_addr;

    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_addr] <= ram_wdata;
            wen_cnt       <= wen_cnt + 1;
            last_wen_addr <= ram_addr;
        end
        if (ram_ren) begin
            ram_rdata <= mem[ram_addr];
            ren_cnt   <= ren_cnt + 1;
        end
        if (ram_ren && ram_wen)
            both_hi <= 1'b1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Transfer list, reference expectations and observed results
    bit          tr_write [MAXT];
    logic [2:0]  tr_size  [MAXT];
    logic [31:0] tr_addr  [MAXT];
    logic [31:0] tr_wdata [MAXT];
    int          tr_gap   [MAXT];
    logic [31:0] exp_rdata[MAXT];
    logic        exp_resp [MAXT];
    int          exp_waits[MAXT];
    logic [31:0] res_rdata[MAXT];
    logic        res_resp [MAXT];
    logic        res_resp0[MAXT];
    int          res_waits[MAXT];
    logic [31:0] ref_mem  [2**ADDR_W];

    function automatic void set_tr(input int i, input bit w, input logic [2:0] s,
                                   input logic [31:0] a, input logic [31:0] d, input int g);
        tr_write[i] = w; tr_size[i] = s; tr_addr[i] = a; tr_wdata[i] = d; tr_gap[i] = g;
    endfunction

    // Transaction-level model: sequential memory semantics with lane masks.
    function automatic void ref_apply(input int i);
        logic [ADDR_W-1:0] w;
        logic [1:0]        a;
        logic [31:0]       mask;
        bit                illegal;
        w = tr_addr[i][ADDR_W+1:2];
        a = tr_addr[i][1:0];
        illegal = (tr_size[i] > 3'd2) || (tr_size[i] == 3'd1 && a[0]) ||
                  (tr_size[i] == 3'd2 && a != 2'd0);
        exp_resp[i]  = 1'b0;
        exp_rdata[i] = 32'h0;
        exp_waits[i] = (!tr_write[i] || tr_size[i] < 3'd2) ? 1 : 0;
`ifdef AHB_RAM_CTRL_ERR_EN
        if (illegal) begin
            exp_resp[i]  = 1'b1;
            exp_waits[i] = 1;
            return;
        end
`else
        if (illegal) exp_resp[i] = 1'b0;
`endif
        if (!tr_write[i]) begin
            exp_rdata[i] = ref_mem[w];
        end else begin
            case (tr_size[i])
                3'd0:    mask = 32'hFF << (8 * a);
                3'd1:    mask = 32'hFFFF << (16 * a[1]);
                default: mask = 32'hFFFF_FFFF;
            endcase
            ref_mem[w] = (ref_mem[w] & ~mask) | (tr_wdata[i] & mask);
        end
    endfunction

    task automatic run_seq(input int n);
        int idx, dp, cyc, budget;
        bit pres, gap_done;
        idx = 0; dp = -1; cyc = 0; budget = 0; gap_done = 0;
        for (int i = 0; i < n; i++) res_waits[i] = -1;
        while ((idx < n || dp >= 0) && budget < 40 * n + 40) begin
            @(negedge clk);
            budget++;
            pres = (idx < n) && (tr_gap[idx] == 0 || gap_done);
            if (pres) begin
                hsel = 1'b1; htrans = 2'b10; hwrite = tr_write[idx];
                hsize = tr_size[idx]; haddr = tr_addr[idx];
            end else if (idx < n && tr_gap[idx] == 2) begin
                hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h100;
            end else begin
                hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h104;
            end
            hwdata = (dp >= 0) ? tr_wdata[dp] : 32'hA5A5_A5A5;
            #1;
            if (dp >= 0) begin
                cyc++;
                if (cyc == 1) res_resp0[dp] = hresp;
            end
            if (hready) begin
                if (dp >= 0) begin
                    res_rdata[dp] = hrdata;
                    res_resp[dp]  = hresp;
                    res_waits[dp] = cyc - 1;
                end
                if (pres) begin
                    dp = idx; idx++; gap_done = 0;
                end else begin
                    dp = -1;
                    if (idx < n) gap_done = 1;
                end
                cyc = 0;
            end
        end
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        n_tests++;
        if (idx < n || dp >= 0) begin
            n_fail++;
            $display("FAIL run_seq_timeout: issued %0d of %0d, data phase pending %0d", idx, n, dp);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        haddr = 32'h0; hwdata = 32'h0;
        #2 n_rst = 1'b0;
        #1;
        n_tests++;
        if ({hready, hresp, ram_ren, ram_wen} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/resp/ren/wen=%b required 1000", {hready, hresp, ram_ren, ram_wen});
        end
        n_tests++;
        if ({hrdata, ram_wdata} !== 64'h0 || ram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_data: hrdata=%h wdata=%h addr=%h required zeros", hrdata, ram_wdata, ram_addr);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_rw();
        set_tr(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        set_tr(1, 0, 3'd2, 32'h10, 32'h0, 0);
        for (int i = 0; i < 2; i++) ref_apply(i);
        run_seq(2);
        n_tests++;
        if (res_waits[0] !== 0 || last_wen_addr !== 10'd4) begin
            n_fail++;
            $display("FAIL word_write: waits=%0d wen_addr=%0d required 0 and 4", res_waits[0], last_wen_addr);
        end
        n_tests++;
        if (res_waits[1] !== 1 || res_rdata[1] !== 32'hDEADBEEF || res_rdata[1] !== exp_rdata[1]) begin
            n_fail++;
            $display("FAIL word_read: waits=%0d data=%h required 1 and deadbeef", res_waits[1], res_rdata[1]);
        end
    endtask

    task automatic test_sub_word();
        set_tr(0, 1, 3'd2, 32'h20, 32'h11223344, 0);
        set_tr(1, 1, 3'd0, 32'h21, 32'h0000AA00, 0);
        for (int i = 0; i < 2; i++) ref_apply(i);
        run_seq(2);
        n_tests++;
        if (mem[8] !== 32'h1122AA44 || mem[8] !== ref_mem[8] || res_waits[1] !== 1) begin
            n_fail++;
            $display("FAIL byte_rmw: word=%h waits=%0d required 1122aa44 and 1", mem[8], res_waits[1]);
        end
        set_tr(0, 1, 3'd2, 32'h20, 32'h11223344, 0);
        set_tr(1, 1, 3'd1, 32'h22, 32'hBEEF0000, 0);
        for (int i = 0; i < 2; i++) ref_apply(i);
        run_seq(2);
        n_tests++;
        if (mem[8] !== 32'hBEEF3344 || mem[8] !== ref_mem[8] || res_waits[1] !== 1) begin
            n_fail++;
            $display("FAIL half_rmw: word=%h waits=%0d required beef3344 and 1", mem[8], res_waits[1]);
        end
    endtask

    task automatic test_back_to_back();
        set_tr(0, 1, 3'd2, 32'h30, 32'h00000005, 0);
        set_tr(1, 0, 3'd2, 32'h30, 32'h0, 0);
        set_tr(2, 1, 3'd0, 32'h30, 32'h00000077, 0);
        for (int i = 0; i < 3; i++) ref_apply(i);
        run_seq(3);
        n_tests++;
        if (res_rdata[1] !== 32'h5 || res_rdata[1] !== exp_rdata[1]) begin
            n_fail++;
            $display("FAIL b2b_read: got %h required 00000005", res_rdata[1]);
        end
        n_tests++;
        if (mem[12] !== 32'h77 || mem[12] !== ref_mem[12]) begin
            n_fail++;
            $display("FAIL b2b_final: got %h required 00000077", mem[12]);
        end
        n_tests++;
        if (res_waits[0] !== 0 || res_waits[1] !== 1 || res_waits[2] !== 1) begin
            n_fail++;
            $display("FAIL b2b_waits: got %0d/%0d/%0d required 0/1/1", res_waits[0], res_waits[1], res_waits[2]);
        end
        n_tests++;
        if (both_hi !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_strobes: ren and wen seen together");
        end
        n_tests++;
        if (hrdata !== 32'h5) begin
            n_fail++;
            $display("FAIL hrdata_hold: got %h required 00000005", hrdata);
        end
    endtask

    task automatic test_misaligned();
        int ren0;
        set_tr(0, 0, 3'd2, 32'h31, 32'h0, 0);
        ref_apply(0);
        ren0 = ren_cnt;
        run_seq(1);
`ifdef AHB_RAM_CTRL_ERR_EN
        n_tests++;
        if (res_resp0[0] !== 1'b1 || res_resp[0] !== 1'b1 || res_waits[0] !== 1) begin
            n_fail++;
            $display("FAIL err_resp: resp0=%b resp=%b waits=%0d required 1 1 1", res_resp0[0], res_resp[0], res_waits[0]);
        end
        n_tests++;
        if (ren_cnt !== ren0) begin
            n_fail++;
            $display("FAIL err_no_ren: %0d reads required 0", ren_cnt - ren0);
        end
`else
        n_tests++;
        if (res_resp[0] !== 1'b0 || res_waits[0] !== 1 || res_rdata[0] !== 32'h77 || res_rdata[0] !== exp_rdata[0]) begin
            n_fail++;
            $display("FAIL misaligned_read: resp=%b waits=%0d data=%h required 0 1 00000077", res_resp[0], res_waits[0], res_rdata[0]);
        end
        n_tests++;
        if (ren_cnt - ren0 !== 1) begin
            n_fail++;
            $display("FAIL misaligned_ren: %0d reads required 1", ren_cnt - ren0);
        end
`endif
    endtask

    task automatic test_reset_mid_rmw();
        int wen0;
        set_tr(0, 1, 3'd2, 32'h40, 32'hCAFEF00D, 0);
        ref_apply(0);
        run_seq(1);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd0; haddr = 32'h41;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h00005500;
        #1;
        n_tests++;
        if ({ram_ren, hready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmw_cycle1: ren/rdy=%b required 10", {ram_ren, hready});
        end
        #1 n_rst = 1'b0;
        #1;
        wen0 = wen_cnt;
        n_tests++;
        if ({hready, hresp, ram_ren, ram_wen} !== 4'b1000 || hrdata !== 32'h0 ||
            ram_wdata !== 32'h0 || ram_addr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy/resp/ren/wen=%b hrdata=%h wdata=%h addr=%h required 1000 and zeros",
                     {hready, hresp, ram_ren, ram_wen}, hrdata, ram_wdata, ram_addr);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (wen_cnt !== wen0 || mem[16] !== 32'hCAFEF00D || mem[16] !== ref_mem[16]) begin
            n_fail++;
            $display("FAIL abort_no_write: writes=%0d word=%h required 0 and cafef00d", wen_cnt - wen0, mem[16]);
        end
    endtask

    task automatic test_random();
        int n, r;
        logic [1:0]  off;
        logic [31:0] a;
        n = 48;
        for (int i = 0; i < 8; i++) set_tr(i, 1, 3'd2, 32'h100 + 32'(4 * i), $urandom, 0);
        for (int i = 8; i < n; i++) begin
            r = $urandom_range(0, 7);
            tr_size[i] = (r == 7) ? 3'd3 : 3'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            if (r != 6) begin
                if (tr_size[i] == 3'd1) off[0] = 1'b0;
                if (tr_size[i] >= 3'd2) off = 2'b00;
            end
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            a[1:0] = off;
            r = $urandom_range(0, 3);
            set_tr(i, bit'($urandom_range(0, 1)), tr_size[i], a, $urandom, (r < 2) ? 0 : r - 1);
        end
        for (int i = 0; i < n; i++) ref_apply(i);
        run_seq(n);
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (res_waits[i] !== exp_waits[i] || res_resp[i] !== exp_resp[i] ||
                (!tr_write[i] && !exp_resp[i] && res_rdata[i] !== exp_rdata[i])) begin
                n_fail++;
                $display("FAIL rand_xfer[%0d]: w=%0d sz=%0d a=%h waits=%0d resp=%b data=%h required waits=%0d resp=%b data=%h",
                         i, tr_write[i], tr_size[i], tr_addr[i], res_waits[i], res_resp[i], res_rdata[i],
                         exp_waits[i], exp_resp[i], exp_rdata[i]);
            end
        end
        for (int w = 64; w < 72; w++) begin
            n_tests++;
            if (mem[w] !== ref_mem[w]) begin
                n_fail++;
                $display("FAIL rand_mem[%0d]: got %h required %h", w, mem[w], ref_mem[w]);
            end
        end
        n_tests++;
        if (both_hi !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_strobes: ren and wen seen together");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_sub_word();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_rmw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
